// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch states,
// datapath widths and the default instruction-memory size.
package cpu_pkg;

   localparam int INSTR_W           = 16;
   localparam int BYTE_W            = 8;
   localparam int MEM_BYTES_DEFAULT = 128;

   typedef enum logic [1:0] {
      ST_HI   = 2'd0,
      ST_LO   = 2'd1,
      ST_WAIT = 2'd2
   } fetchState_t;

   // Reduce a byte address into a power-of-two memory window.
   function automatic logic [15:0] memIndex(input logic [15:0] addr, input logic [15:0] mask);
      return addr & mask;
   endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetcher: reads high then low byte from a byte-wide
// memory, presents the assembled instruction on a valid/ready output slot.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic                 i_clk,
   input  logic                 i_rstN,
   input  logic                 i_enable,
   output logic [15:0]          o_memAddr,
   output logic                 o_memRd,
   input  logic [BYTE_W-1:0]    i_memData,
   output logic [INSTR_W-1:0]   o_instruction,
   output logic [15:0]          o_instrPc,
   output logic                 o_instrValid,
   input  logic                 i_instrReady,
   input  logic                 i_branch,
   input  logic [15:0]          i_branchTarget
);

   localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);
   localparam logic [15:0] PC_RESET  = RESET_PC & 16'hFFFE;

   fetchState_t          r_state;
   logic [15:0]          r_pc;
   logic [BYTE_W-1:0]    r_hiByte;
   logic [INSTR_W-1:0]   r_instr;
   logic [15:0]          r_instrPc;
   logic                 r_valid;

   fetchState_t          w_stateNext;
   logic [15:0]          w_pcNext;
   logic [BYTE_W-1:0]    w_hiNext;
   logic [INSTR_W-1:0]   w_instrNext;
   logic [15:0]          w_instrPcNext;
   logic                 w_validNext;
   logic                 w_slotFree;
   logic [15:0]          w_pcPlus1;

   assign w_slotFree = !r_valid || i_instrReady;
   assign w_pcPlus1  = r_pc + 16'd1;

   assign o_memAddr     = memIndex((r_state == ST_HI) ? r_pc : w_pcPlus1, ADDR_MASK);
   assign o_memRd       = (r_state == ST_HI) ? i_enable : 1'b1;
   assign o_instruction = r_instr;
   assign o_instrPc     = r_instrPc;
   assign o_instrValid  = r_valid;

   // Branch overrides everything; otherwise a transfer empties the slot
   // unless the low-byte read refills it in the same cycle.
   always_comb begin
      w_stateNext   = r_state;
      w_pcNext      = r_pc;
      w_hiNext      = r_hiByte;
      w_instrNext   = r_instr;
      w_instrPcNext = r_instrPc;
      w_validNext   = r_valid;

      if (i_branch) begin
         w_stateNext = ST_HI;
         w_pcNext    = i_branchTarget & 16'hFFFE;
         w_hiNext    = '0;
         w_validNext = 1'b0;
      end else begin
         if (r_valid && i_instrReady) begin
            w_validNext = 1'b0;
         end
         case (r_state)
            ST_HI: begin
               if (i_enable) begin
                  w_hiNext    = i_memData;
                  w_stateNext = ST_LO;
               end
            end
            ST_LO, ST_WAIT: begin
               if (w_slotFree) begin
                  w_instrNext   = {r_hiByte, i_memData};
                  w_instrPcNext = r_pc;
                  w_validNext   = 1'b1;
                  w_pcNext      = r_pc + 16'd2;
                  w_stateNext   = ST_HI;
               end else begin
                  w_stateNext = ST_WAIT;
               end
            end
            default: begin
               w_stateNext = ST_HI;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_state   <= ST_HI;
         r_pc      <= PC_RESET;
         r_hiByte  <= '0;
         r_instr   <= '0;
         r_instrPc <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_pc      <= w_pcNext;
         r_hiByte  <= w_hiNext;
         r_instr   <= w_instrNext;
         r_instrPc <= w_instrPcNext;
         r_valid   <= w_validNext;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a 128-byte instruction memory model and
// hand-computed expectations for fetch, stall, branch, wrap, enable and reset.
module tb_fetch_sequencer;
   import cpu_pkg::*;

   logic        i_clk;
   logic        i_rstN;
   logic        i_enable;
   logic [15:0] o_memAddr;
   logic        o_memRd;
   logic [7:0]  i_memData;
   logic [15:0] o_instruction;
   logic [15:0] o_instrPc;
   logic        o_instrValid;
   logic        i_instrReady;
   logic        i_branch;
   logic [15:0] i_branchTarget;

   logic [7:0]  mem [0:127];
   int          checkCount;
   int          passCount;

   fetch_sequencer #(
      .RESET_PC  (16'h0000),
      .MEM_BYTES (128)
   ) dut (
      .i_clk          (i_clk),
      .i_rstN         (i_rstN),
      .i_enable       (i_enable),
      .o_memAddr      (o_memAddr),
      .o_memRd        (o_memRd),
      .i_memData      (i_memData),
      .o_instruction  (o_instruction),
      .o_instrPc      (o_instrPc),
      .o_instrValid   (o_instrValid),
      .i_instrReady   (i_instrReady),
      .i_branch       (i_branch),
      .i_branchTarget (i_branchTarget)
   );

   assign i_memData = mem[o_memAddr[6:0]];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic rdy, input logic br, input logic [15:0] tgt);
      i_enable       = en;
      i_instrReady   = rdy;
      i_branch       = br;
      i_branchTarget = tgt;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic resetSequence();
      i_rstN = 1'b0;
      tick();
      i_rstN = 1'b1;
   endtask

   task automatic checkInstr(input string tag, input logic [15:0] instr, input logic [15:0] pc);
      checkOutput({tag, "_valid"}, 32'(o_instrValid), 32'd1);
      checkOutput({tag, "_instr"}, 32'(o_instruction), 32'(instr));
      checkOutput({tag, "_pc"}, 32'(o_instrPc), 32'(pc));
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
      mem[3] = 8'h78; mem[4] = 8'h9A; mem[5] = 8'hBC;
      mem[6] = 8'h11; mem[7] = 8'h22;
      mem[126] = 8'hDE; mem[127] = 8'hAD;

      // Reset state and straight-line fetch with the consumer always ready.
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      i_rstN = 1'b0;
      #2;
      checkOutput("rst_valid", 32'(o_instrValid), 32'd0);
      checkOutput("rst_instr", 32'(o_instruction), 32'd0);
      checkOutput("rst_pc", 32'(o_instrPc), 32'd0);
      checkOutput("rst_addr", 32'(o_memAddr), 32'd0);
      checkOutput("rst_rd", 32'(o_memRd), 32'd1);
      resetSequence();
      tick();
      checkOutput("s1_lo_addr", 32'(o_memAddr), 32'd1);
      checkOutput("s1_lo_valid", 32'(o_instrValid), 32'd0);
      tick();
      checkInstr("s1_i0", 16'h1234, 16'd0);
      checkOutput("s1_hi_addr", 32'(o_memAddr), 32'd2);
      tick();
      checkOutput("s1_gap_valid", 32'(o_instrValid), 32'd0);
      tick();
      checkInstr("s1_i1", 16'h5678, 16'd2);
      tick();
      checkOutput("s1_gap2_valid", 32'(o_instrValid), 32'd0);
      tick();
      checkInstr("s1_i2", 16'h9ABC, 16'd4);

      // Consumer stalls for five cycles after the first instruction.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      resetSequence();
      tick();
      tick();
      checkInstr("s2_i0", 16'h1234, 16'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         checkOutput("s2_hold_instr", 32'(o_instruction), 32'h1234);
         checkOutput("s2_hold_valid", 32'(o_instrValid), 32'd1);
      end
      checkOutput("s2_state", 32'(dut.r_state), 32'(ST_WAIT));
      checkOutput("s2_addr", 32'(o_memAddr), 32'd3);
      checkOutput("s2_rd", 32'(o_memRd), 32'd1);
      i_instrReady = 1'b1;
      tick();
      checkInstr("s2_i1", 16'h5678, 16'd2);

      // Branch to an odd target while the low byte is being read.
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      resetSequence();
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0007);
      tick();
      checkOutput("s3_flush_valid", 32'(o_instrValid), 32'd0);
      checkOutput("s3_addr", 32'(o_memAddr), 32'd6);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      tick();
      checkOutput("s3_lo_addr", 32'(o_memAddr), 32'd7);
      tick();
      checkInstr("s3_i", 16'h1122, 16'd6);

      // Address wraps at the top of memory while the PC keeps counting.
      applyStimulus(1'b1, 1'b1, 1'b1, 16'd126);
      tick();
      checkOutput("s4_flush_valid", 32'(o_instrValid), 32'd0);
      checkOutput("s4_addr126", 32'(o_memAddr), 32'd126);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      tick();
      checkOutput("s4_addr127", 32'(o_memAddr), 32'd127);
      tick();
      checkInstr("s4_i126", 16'hDEAD, 16'd126);
      checkOutput("s4_addr0", 32'(o_memAddr), 32'd0);
      tick();
      checkOutput("s4_addr1", 32'(o_memAddr), 32'd1);
      tick();
      checkInstr("s4_i128", 16'h1234, 16'd128);

      // Fetch held off with enable low, then resumes at the same PC.
      i_enable = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         checkOutput("s5_rd", 32'(o_memRd), 32'd0);
         checkOutput("s5_valid", 32'(o_instrValid), 32'd0);
         checkOutput("s5_addr", 32'(o_memAddr), 32'd2);
      end
      i_enable = 1'b1;
      #1;
      checkOutput("s5_rd_resume", 32'(o_memRd), 32'd1);
      tick();
      tick();
      checkInstr("s5_i130", 16'h5678, 16'd130);

      // Asynchronous reset arrives while a low byte is in flight.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      resetSequence();
      tick();
      tick();
      tick();
      checkOutput("s6_pre_valid", 32'(o_instrValid), 32'd1);
      checkOutput("s6_pre_addr", 32'(o_memAddr), 32'd3);
      #2;
      i_rstN = 1'b0;
      #1;
      checkOutput("s6_rst_valid", 32'(o_instrValid), 32'd0);
      checkOutput("s6_rst_instr", 32'(o_instruction), 32'd0);
      checkOutput("s6_rst_pc", 32'(o_instrPc), 32'd0);
      checkOutput("s6_rst_addr", 32'(o_memAddr), 32'd0);
      i_instrReady = 1'b1;
      tick();
      i_rstN = 1'b1;
      tick();
      tick();
      checkInstr("s6_i0", 16'h1234, 16'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
